// File: rtl/lsu_mem_port.sv
// Load/store port from the RV32I execute stage to a word-addressed data memory.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses complete with an error.
module lsu_mem_port #(
    parameter int unsigned MEM_IDX_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_done,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic        mem_WE,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [MEM_IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]             off_q, off_d;
    logic [2:0]             f3_q, f3_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [31:0]            merge_q, merge_d;

    logic                   accept;
    logic                   illegal;
    logic                   req_err;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic [31:0]            load_ext;
    logic [31:0]            merged;
    logic                   unused_addr_hi;

    // Address bits above the word index are dropped, so accesses wrap modulo memory size.
    assign unused_addr_hi = ^req_addr[31:MEM_IDX_W+2];

    always_comb begin
        illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                  (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = illegal ||
                  ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        req_err = illegal;
`endif
    end

    // Lane selection uses only the bits meaningful for the access size, which
    // implicitly aligns H/HU and W when misalignment is not trapped.
    always_comb begin
        byte_sel = mem_RD[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = mem_RD;
        endcase
    end

    always_comb begin
        merged = mem_RD;
        if (f3_q[0]) begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (req_funct3[1:0] == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        off_d   = off_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        if (accept) begin
            idx_d   = req_addr[MEM_IDX_W+1:2];
            off_d   = req_addr[1:0];
            f3_d    = req_funct3;
            wdata_d = req_wdata;
            err_d   = req_err;
            rdata_d = '0;
            merge_d = req_wdata;
        end else if (state_q == LOAD) begin
            rdata_d = load_ext;
        end else if (state_q == RMW_RD) begin
            merge_d = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    // Outputs are gated by rst so a reset cycle never writes memory or pulses done.
    always_comb begin
        req_ready  = rst || (state_q == IDLE);
        resp_done  = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_A      = '0;
        mem_WE     = 1'b0;
        mem_WD     = '0;
        if (!rst) begin
            if (state_q != IDLE) begin
                mem_A = {{(32-MEM_IDX_W){1'b0}}, idx_q};
            end
            if (state_q == WRITE) begin
                mem_WE = 1'b1;
                mem_WD = merge_q;
            end
            if (state_q == RESP) begin
                resp_done  = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized self-checking bench for lsu_mem_port with a word-array memory and reference model.
// Expectations follow the LSU_MISALIGN_TRAP_EN setting of the build.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_done;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(.MEM_IDX_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_done  (resp_done),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    assign mem_RD = mem[mem_A[9:0]];

    always @(posedge clk) begin
        if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        logic [31:0] idx, word, v, nw, exp_rd;
        int unsigned sh, exp_lat, exp_we_cyc;
        bit          ill, mis, exp_err;
        int          w, done_cyc, we_cnt, we_cyc;
        logic [31:0] we_a, we_d, got_rd;
        logic        got_err;

        idx  = (a / 4) % 1024;
        word = ref_mem[idx];
        ill  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (st && (f3 == 4 || f3 == 5));
        mis  = ((f3 == 1 || f3 == 5) && (a % 2 != 0)) || (f3 == 2 && (a % 4 != 0));
`ifdef LSU_MISALIGN_TRAP_EN
        exp_err = ill || mis;
`else
        exp_err = ill;
`endif
        exp_rd = 0;
        nw     = word;
        if (!exp_err && !st) begin
            case (f3)
                0, 4: begin
                    v = (word >> ((a % 4) * 8)) & 32'hFF;
                    exp_rd = (f3 == 0 && v >= 128) ? v + 32'hFFFFFF00 : v;
                end
                1, 5: begin
                    v = (word >> (((a / 2) % 2) * 16)) & 32'hFFFF;
                    exp_rd = (f3 == 1 && v >= 32768) ? v + 32'hFFFF0000 : v;
                end
                default: exp_rd = word;
            endcase
        end else if (!exp_err) begin
            if (f3 == 0) begin
                sh = (a % 4) * 8;
                nw = (word & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end else if (f3 == 1) begin
                sh = ((a / 2) % 2) * 16;
                nw = (word & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end else begin
                nw = wd;
            end
        end
        exp_lat    = exp_err ? 1 : ((!st || f3 == 2) ? 2 : 3);
        exp_we_cyc = (f3 == 2) ? 1 : 2;

        w = 0;
        while (!req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);

        done_cyc = 0;
        we_cnt   = 0;
        we_cyc   = 0;
        we_a     = 0;
        we_d     = 0;
        got_rd   = 0;
        got_err  = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            chk("mem_A_busy", mem_A, idx);
            if (mem_WE) begin
                we_cnt++;
                we_cyc = cyc;
                we_a   = mem_A;
                we_d   = mem_WD;
            end
            if (resp_done) begin
                done_cyc  = cyc;
                got_rd    = resp_rdata;
                got_err   = resp_err;
                req_valid = 1'b0;
                break;
            end
            // Requests presented while busy must be ignored.
            req_valid  = $urandom_range(0, 1) == 1;
            req_store  = $urandom_range(0, 1) == 1;
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
        req_valid = 1'b0;

        chk("latency", done_cyc, exp_lat);
        chk("resp_err", {31'd0, got_err}, {31'd0, exp_err});
        chk("resp_rdata", got_rd, exp_rd);
        chk("we_count", we_cnt, (st && !exp_err) ? 1 : 0);
        if (st && !exp_err) begin
            chk("we_cycle", we_cyc, exp_we_cyc);
            chk("we_addr", we_a, idx);
            chk("we_data", we_d, nw);
        end
        ref_mem[idx] = nw;

        @(negedge clk);
        chk("done_one_cycle", {31'd0, resp_done}, 32'd0);
        chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
        chk("mem_A_idle", mem_A, 32'd0);
        chk("mem_contents", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[64]     = 32'h8081F2A3;
        ref_mem[64] = 32'h8081F2A3;

        repeat (3) @(negedge clk);
        chk("rst_done", {31'd0, resp_done}, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_A", mem_A, 32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);
        chk("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        do_req(0, 3'b000, 32'h101, 0);
        chk("lb_0x101", resp_rdata, 32'h0);
        do_req(0, 3'b100, 32'h103, 0);
        do_req(0, 3'b001, 32'h102, 0);
        do_req(0, 3'b101, 32'h100, 0);
        do_req(0, 3'b010, 32'h100, 0);
        do_req(1, 3'b000, 32'h102, 32'h12345655);
        chk("sb_readback", mem[64], 32'h8055F2A3);
        do_req(1, 3'b010, 32'h0FFC, 32'hDEADBEEF);
        do_req(1, 3'b010, 32'h1000, 32'h0BADF00D);
        do_req(0, 3'b010, 32'h101, 0);
        do_req(0, 3'b011, 32'h100, 0);
        do_req(1, 3'b100, 32'h100, 32'h1);

        // Reset in RMW_RD abandons the SH: no write, no response.
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h100;
        req_wdata  = 32'hCAFE1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        chk("rmw_rst_we", {31'd0, mem_WE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rmw_rst_no_we", {31'd0, mem_WE}, 32'd0);
            chk("rmw_rst_no_done", {31'd0, resp_done}, 32'd0);
        end
        chk("rmw_rst_mem", mem[64], ref_mem[64]);

        // Reset asserted while in WRITE must suppress the write.
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h200;
        req_wdata  = ~ref_mem[128];
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("wr_rst_we", {31'd0, mem_WE}, 32'd0);
        chk("wr_rst_mem_A", mem_A, 32'd0);
        chk("wr_rst_done", {31'd0, resp_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("wr_rst_no_done", {31'd0, resp_done}, 32'd0);
        end
        chk("wr_rst_mem", mem[128], ref_mem[128]);

        for (int n = 0; n < 300; n++) begin
            do_req($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 32'h3FFF)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
